// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-stage types and default widths
// Contents:
//   fetch_state_e  : request tracking state of the fetch unit
//   FETCH_ADDR_W   : default PC / instruction-memory address width
//   FETCH_INSTR_W  : default instruction word width
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 8;
  localparam int FETCH_INSTR_W = 9;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,  // nothing outstanding
    FETCH_WAIT = 2'd1,  // request outstanding, response will be kept
    FETCH_DROP = 2'd2   // request outstanding, response will be discarded
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small instruction buffer between fetch and decode
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   push, wdata    : write wdata at the tail (ignored when full)
//   pop            : drop the head entry (ignored when empty)
//   clear          : empty the buffer; overrides push and pop
//   head           : entry at the head (stale when count==0)
//   count          : number of valid entries
module fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 17,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count < CNT_W'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Storage is reset so the head reads as zero out of reset.
  // Pointers rely on natural overflow, so DEPTH must be a power of two.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with one outstanding read
// Ports:
//   clk_i, rst_n_i              : clock, asynchronous active-low reset
//   pc_i, pc_valid_i, pc_ready_o: PC handshake from the PC stage
//   flush_i                     : discard buffered and in-flight instructions
//   imem_req_o, imem_addr_o     : instruction memory read request
//   imem_rvalid_i, imem_rdata_i : instruction memory read response
//   instr_valid_o, instr_o,
//   instr_pc_o, instr_ready_i   : buffered instruction handshake to decode
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = FETCH_ADDR_W,
  parameter int INSTR_W = FETCH_INSTR_W,
  parameter int DEPTH   = 2
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic               pc_valid_i,
  output logic               pc_ready_o,
  input  logic               flush_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  instr_pc_o,
  input  logic               instr_ready_i
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_e                state;
  logic [ADDR_W-1:0]           pc_q;
  logic [CNT_W-1:0]            count;
  logic [ADDR_W+INSTR_W-1:0]   head;
  logic                        push;
  logic                        pop;

  // Space is checked at issue time, so the single in-flight response
  // always has a free slot when it returns.
  assign pc_ready_o  = (state == FETCH_IDLE) && (count < CNT_W'(DEPTH)) && !flush_i;
  assign imem_req_o  = pc_valid_i && pc_ready_o;
  assign imem_addr_o = pc_i;

  assign push = (state == FETCH_WAIT) && imem_rvalid_i && !flush_i;
  assign pop  = instr_ready_i && instr_valid_o;

  assign instr_valid_o        = (count != '0);
  assign {instr_pc_o, instr_o} = head;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= FETCH_IDLE;
      pc_q  <= '0;
    end else begin
      case (state)
        FETCH_IDLE: begin
          // A response here is a protocol error and is ignored.
          if (imem_req_o) begin
            state <= FETCH_WAIT;
            pc_q  <= pc_i;
          end
        end
        FETCH_WAIT: begin
          // With a coincident flush the response is simply not pushed.
          if (imem_rvalid_i)  state <= FETCH_IDLE;
          else if (flush_i)   state <= FETCH_DROP;
        end
        FETCH_DROP: begin
          if (imem_rvalid_i)  state <= FETCH_IDLE;
        end
        default: state <= FETCH_IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + INSTR_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push    (push),
    .wdata   ({pc_q, imem_rdata_i}),
    .pop     (pop),
    .clear   (flush_i),
    .head    (head),
    .count   (count)
  );

endmodule
